// File: rtl/span_pkg.sv
// Shared constants and FSM state type for the span margin master.
// Register-map offsets follow the slave's layout.
package span_pkg;

  localparam int NUM_REGS = 34;

  localparam logic [5:0] OFF_PSR       = 6'd0;
  localparam logic [5:0] OFF_POS0      = 6'd1;
  localparam logic [5:0] OFF_POS7      = 6'd8;
  localparam logic [5:0] OFF_INTERRATE = 6'd13;
  localparam logic [5:0] OFF_MAT0      = 6'd14;
  localparam logic [5:0] OFF_TIER0     = 6'd22;
  localparam logic [5:0] OFF_SPREAD0   = 6'd25;
  localparam logic [5:0] OFF_OUTRIGHT2 = 6'd33;

  localparam logic [5:0] LAST_OFF = OFF_OUTRIGHT2;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    SETTLE,
    READ,
    CAPTURE,
    DONE
  } span_state_e;

endpackage

// File: rtl/span_shadow_regs.sv
// 34x16 shadow parameter store: one write port, one combinational
// read port, cleared by reset.
module span_shadow_regs
  import span_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [5:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [5:0]  raddr,
  output logic [15:0] rdata
);

  logic [15:0] mem_q [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && waddr <= LAST_OFF) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = (raddr <= LAST_OFF) ? mem_q[raddr] : '0;

endmodule

// File: rtl/span_master.sv
// Replays the shadow store into the slave, settles, reads the margin.
// Define SPAN_MASTER_RETRY_EN to replay on a zero margin.
module span_master
  import span_pkg::*;
#(
  parameter int SETTLE_CYCLES = 64,
  parameter int MAX_RETRY     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_wr,
  input  logic [5:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  input  logic        start,
  output logic        busy,
  output logic [15:0] margin,
  output logic        margin_valid,
  output logic        chipselect,
  output logic        write,
  output logic        read,
  output logic [5:0]  offset,
  output logic [15:0] writeData,
  input  logic [15:0] readData
);

`ifdef SPAN_MASTER_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam int CW = 16;

  span_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    retry_q, retry_d;
  logic [15:0]   margin_q, margin_d;
  logic [15:0]   shadow_rd;
  logic          shadow_we;

  assign shadow_we = cfg_wr && (state_q == IDLE);

  span_shadow_regs u_shadow (
    .clk   (clk),
    .rst_n (reset),
    .we    (shadow_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (cnt_q[5:0]),
    .rdata (shadow_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      retry_q  <= '0;
      margin_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      margin_q <= margin_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    margin_d = margin_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WRITE;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      WRITE: begin
        if (cnt_q == CW'(LAST_OFF)) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          state_d = READ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READ: state_d = CAPTURE;
      CAPTURE: begin
        margin_d = readData;
        // slave clears its inputs on read, so a retry is a full replay
        if (RETRY_EN && readData == '0 &&
            retry_q < 8'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          state_d = WRITE;
          cnt_d   = '0;
        end else begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    chipselect   = 1'b0;
    write        = 1'b0;
    read         = 1'b0;
    offset       = '0;
    writeData    = '0;
    margin_valid = 1'b0;
    busy         = (state_q != IDLE);
    unique case (state_q)
      WRITE: begin
        chipselect = 1'b1;
        write      = 1'b1;
        offset     = cnt_q[5:0];
        writeData  = shadow_rd;
      end
      READ: begin
        chipselect = 1'b1;
        read       = 1'b1;
      end
      DONE: margin_valid = 1'b1;
      default: ;
    endcase
  end

  assign margin = margin_q;

endmodule

// File: tb/tb_span_master.sv
// Scoreboard bench for span_master: queued expected writes and margins,
// compared as the slave bus and margin_valid are observed.
module tb_span_master;
  import span_pkg::*;

  localparam int S = 64;

`ifdef SPAN_MASTER_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [5:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        start = 1'b0;
  logic        busy;
  logic [15:0] margin;
  logic        margin_valid;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [5:0]  offset;
  logic [15:0] writeData;
  logic [15:0] readData = '0;

  span_master #(.SETTLE_CYCLES(S), .MAX_RETRY(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_wr       (cfg_wr),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .start        (start),
    .busy         (busy),
    .margin       (margin),
    .margin_valid (margin_valid),
    .chipselect   (chipselect),
    .write        (write),
    .read         (read),
    .offset       (offset),
    .writeData    (writeData),
    .readData     (readData)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;

  logic [15:0] model [NUM_REGS];
  logic [21:0] exp_wr [$];
  logic [15:0] exp_m [$];
  int          exp_c [$];
  logic [15:0] resp [$];
  logic [21:0] e;
  int n_rd = 0;
  int last_wr = 0;
  int done_cnt = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // slave: read data appears the cycle after the read strobe
  always @(posedge clk) begin
    if (chipselect && read) begin
      if (resp.size() > 0) readData <= resp.pop_front();
      else readData <= 16'h0;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("excl", 32'(write & read), 32'd0);
      chk("cs", 32'(chipselect), 32'(write | read));
      if (write) begin
        if (exp_wr.size() == 0) begin
          chk("wr_unexp", 32'd1, 32'd0);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_off", 32'(offset), 32'(e[21:16]));
          chk("wr_dat", 32'(writeData), 32'(e[15:0]));
        end
        last_wr = cyc;
      end
      if (read) begin
        n_rd++;
        chk("rd_gap", 32'(cyc - last_wr), 32'(S + 1));
      end
      if (margin_valid) begin
        done_cnt++;
        if (exp_m.size() == 0) begin
          chk("mv_unexp", 32'd1, 32'd0);
        end else begin
          chk("margin", 32'(margin), 32'(exp_m.pop_front()));
          chk("mv_cyc", 32'(cyc), 32'(exp_c.pop_front()));
        end
      end
    end
  end

  task automatic cfg(logic [5:0] a, logic [15:0] d, bit take);
    @(negedge clk);
    cfg_wr = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    if (take && a < 6'(NUM_REGS)) model[a] = d;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  // mode 1: second start at cycle 10; mode 2: cfg_wr addr 5 at cycle 10
  task automatic run(int nseq, int mode, logic [15:0] exp_margin);
    int c0;
    int n;
    for (int s = 0; s < nseq; s++)
      for (int k = 0; k < NUM_REGS; k++)
        exp_wr.push_back({6'(k), model[k]});
    n_rd = 0;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    exp_m.push_back(exp_margin);
    exp_c.push_back(c0 + 1 + nseq * (36 + S));
    @(negedge clk);
    start = 1'b0;
    chk("busy_run", 32'(busy), 32'd1);
    if (mode != 0) begin
      repeat (9) @(negedge clk);
      if (mode == 1) start = 1'b1;
      else begin
        cfg_wr = 1'b1;
        cfg_addr = 6'd5;
        cfg_data = 16'hDEAD;
      end
      @(negedge clk);
      start = 1'b0;
      cfg_wr = 1'b0;
    end
    n = 0;
    while (done_cnt == 0 && n < nseq * (40 + S) + 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("done_n", 32'(done_cnt), 32'd1);
    chk("wr_left", 32'(exp_wr.size()), 32'd0);
    chk("rd_n", 32'(n_rd), 32'(nseq));
    chk("busy_end", 32'(busy), 32'd0);
    chk("margin_hold", 32'(margin), 32'(exp_margin));
    exp_wr.delete();
    exp_m.delete();
    exp_c.delete();
    resp.delete();
  endtask

  initial begin
    int n;
    for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mv", 32'(margin_valid), 32'd0);
    chk("rst_margin", 32'(margin), 32'd0);
    chk("rst_strobes", 32'({chipselect, write, read}), 32'd0);
    chk("rst_off", 32'(offset), 32'd0);
    chk("rst_wd", 32'(writeData), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int k = 0; k < NUM_REGS; k++) cfg(6'(k), 16'(k + 'h100), 1'b1);
    resp.push_back(16'h1234);
    run(1, 0, 16'h1234);

    resp.push_back(16'h0777);
    run(1, 1, 16'h0777);

    cfg(6'd40, 16'hBEEF, 1'b0);
    resp.push_back(16'h0101);
    run(1, 2, 16'h0101);
    resp.push_back(16'h0202);
    run(1, 0, 16'h0202);

    // abort mid-run at offset 20
    for (int k = 0; k < NUM_REGS; k++) exp_wr.push_back({6'(k), model[k]});
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(write && offset == 6'd20) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("off20_seen", 32'(n < 100), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_strobes", 32'({chipselect, write, read}), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_off", 32'(offset), 32'd0);
    chk("abort_wd", 32'(writeData), 32'd0);
    exp_wr.delete();
    for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (150) @(negedge clk);
    chk("abort_no_mv", 32'(done_cnt), 32'd0);

    resp.push_back(16'h0033);
    run(1, 0, 16'h0033);

    for (int k = 0; k < NUM_REGS; k++) cfg(6'(k), 16'(k * 3 + 'h2000), 1'b1);
    resp.push_back(16'h0000);
    resp.push_back(16'h0000);
    resp.push_back(16'h0050);
    if (RETRY) run(3, 0, 16'h0050);
    else run(1, 0, 16'h0000);

    if (RETRY) run(4, 0, 16'h0000);
    else run(1, 0, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
